// File: rtl/wb_spi_flash_reader.sv
// Wishbone classic slave that turns each 32-bit read into a SPI-flash READ (0x03) command.
// Writes are refused with a one-cycle error; the bus is held with wait states until the word is back.
module wb_spi_flash_reader #(
  parameter int CLK_DIV        = 2,
  parameter int CS_HIGH_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        spi_sck_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic [2:0]  o_dbg_state
);

  // Handshake: a request is cyc&stb sampled in IDLE; it completes with exactly one of
  // ack (read) or err (write) high for one cycle; the master must drop stb after that.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4,
    S_DESEL = 3'd5
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] CS_LAST  = 16'(CS_HIGH_CYCLES - 1);

  state_t      r_state, w_state_nx;
  logic [15:0] r_div, w_div_nx;
  logic [4:0]  r_bit, w_bit_nx;
  logic [31:0] r_tx, w_tx_nx;
  logic [31:0] r_rx, w_rx_nx;
  logic [31:0] r_dat, w_dat_nx;
  logic        r_sck, w_sck_nx;
  logic        r_cs_n, w_cs_n_nx;
  logic        r_mosi, w_mosi_nx;
  logic        r_ack, r_err;
  logic        w_div_end;
  logic        w_unused;

  assign w_unused = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:24], wb_adr_i[1:0]};
  assign w_div_end = (r_div == DIV_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dat   <= '0;
      r_sck   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_bit   <= w_bit_nx;
      r_tx    <= w_tx_nx;
      r_rx    <= w_rx_nx;
      r_dat   <= w_dat_nx;
      r_sck   <= w_sck_nx;
      r_cs_n  <= w_cs_n_nx;
      r_mosi  <= w_mosi_nx;
      r_ack   <= (w_state_nx == S_DONE);
      r_err   <= (w_state_nx == S_ERR);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_bit_nx   = r_bit;
    w_tx_nx    = r_tx;
    w_rx_nx    = r_rx;
    w_dat_nx   = r_dat;
    w_sck_nx   = r_sck;
    w_cs_n_nx  = r_cs_n;
    w_mosi_nx  = r_mosi;
    case (r_state)
      S_IDLE: begin
        w_cs_n_nx = 1'b1;
        w_sck_nx  = 1'b0;
        w_mosi_nx = 1'b0;
        w_div_nx  = '0;
        w_bit_nx  = '0;
        if (wb_cyc_i && wb_stb_i) begin
          if (wb_we_i) begin
            w_state_nx = S_ERR;
          end else begin
            w_state_nx = S_CMD;
            w_tx_nx    = {8'h03, wb_adr_i[23:2], 2'b00};
            w_cs_n_nx  = 1'b0;
            w_mosi_nx  = w_tx_nx[31];
          end
        end
      end
      S_CMD, S_DATA: begin
        if (!wb_cyc_i) begin
          w_state_nx = S_DESEL;
          w_cs_n_nx  = 1'b1;
          w_sck_nx   = 1'b0;
          w_mosi_nx  = 1'b0;
          w_div_nx   = '0;
        end else if (!w_div_end) begin
          w_div_nx = r_div + 16'd1;
        end else begin
          w_div_nx = '0;
          w_sck_nx = ~r_sck;
          if (!r_sck) begin
            // Rising SCK: the flash drives MISO on the falling edge, so it is stable here.
            if (r_state == S_DATA) w_rx_nx = {r_rx[30:0], spi_miso_i};
          end else if (r_bit == 5'd31) begin
            w_bit_nx = '0;
            if (r_state == S_CMD) begin
              w_state_nx = S_DATA;
              w_mosi_nx  = 1'b0;
            end else begin
              w_state_nx = S_DONE;
              w_cs_n_nx  = 1'b1;
              w_dat_nx   = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
            end
          end else begin
            w_bit_nx  = r_bit + 5'd1;
            w_tx_nx   = {r_tx[30:0], 1'b0};
            w_mosi_nx = (r_state == S_CMD) ? r_tx[30] : 1'b0;
          end
        end
      end
      S_DONE, S_ERR: begin
        w_state_nx = S_DESEL;
        w_div_nx   = '0;
      end
      S_DESEL: begin
        w_cs_n_nx = 1'b1;
        w_sck_nx  = 1'b0;
        w_mosi_nx = 1'b0;
        if (r_div == CS_LAST) begin
          w_state_nx = S_IDLE;
          w_div_nx   = '0;
        end else begin
          w_div_nx = r_div + 16'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign wb_dat_o    = r_dat;
  assign wb_ack_o    = r_ack;
  assign wb_err_o    = r_err;
  assign spi_sck_o   = r_sck;
  assign spi_cs_n_o  = r_cs_n;
  assign spi_mosi_o  = r_mosi;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_spi_flash_reader.sv
// Directed bench for wb_spi_flash_reader: a behavioural SPI flash answers READ commands,
// and each scenario compares bus/SPI outputs against hand-computed values.
module tb_wb_spi_flash_reader;

  localparam int CLK_DIV        = 2;
  localparam int CS_HIGH_CYCLES = 2;
  localparam int LAT_EDGES      = 128 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = 4'hF;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] dat_o;
  logic        ack, err, sck, cs_n, mosi;
  logic        miso = 1'b0;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  wb_spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_HIGH_CYCLES(CS_HIGH_CYCLES)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .spi_sck_o(sck), .spi_cs_n_o(cs_n), .spi_mosi_o(mosi),
    .spi_miso_i(miso), .o_dbg_state(dbg_state)
  );

  // behavioural SPI flash (mode 0)
  logic [7:0]  mem [0:511];
  int          fl_cnt = 0;
  logic [31:0] fl_cmd = '0;
  int          sck_rises = 0;
  int          ack_cnt = 0;
  int          hi_cnt = 0;
  int          last_hi = 0;

  always @(negedge cs_n) begin
    fl_cnt = 0;
    fl_cmd = '0;
  end

  always @(posedge sck) begin
    sck_rises++;
    if (!cs_n) begin
      if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], mosi};
      fl_cnt++;
    end
  end

  always @(negedge sck) begin
    int k;
    logic [8:0] a;
    logic [7:0] b;
    if (!cs_n && fl_cnt >= 32 && fl_cnt < 64) begin
      k = fl_cnt - 32;
      a = fl_cmd[8:0] + 9'(k / 8);
      b = mem[a];
      miso = b[7 - (k % 8)];
    end
  end

  always @(posedge ack) ack_cnt++;

  always @(negedge clk) begin
    if (cs_n) hi_cnt++;
    else begin
      if (hi_cnt != 0) last_hi = hi_cnt;
      hi_cnt = 0;
    end
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dat"}, dat_o, 32'h0);
    check({tag, "_ack"}, {31'b0, ack}, 32'h0);
    check({tag, "_err"}, {31'b0, err}, 32'h0);
    check({tag, "_sck"}, {31'b0, sck}, 32'h0);
    check({tag, "_csn"}, {31'b0, cs_n}, 32'h1);
    check({tag, "_mosi"}, {31'b0, mosi}, 32'h0);
    check({tag, "_state"}, {29'b0, dbg_state}, 32'h0);
  endtask

  // driver: optionally starts a read at the next edge, then waits (bounded) for ack.
  // lat = number of edges after the sampling edge until ack is seen.
  task automatic wait_ack(input string tag, input int budget, input logic hold,
                          input logic [31:0] next_adr, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check({tag, "_ack_timeout"}, 32'h0, 32'h1);
    else check({tag, "_csn_at_ack"}, {31'b0, cs_n}, 32'h1);
    if (hold) adr = next_adr;
    else begin
      cyc = 1'b0;
      stb = 1'b0;
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic w);
    @(negedge clk);
    adr = a; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [31:0] prev;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
    mem[4] = 8'h01; mem[5] = 8'h23; mem[6] = 8'h45; mem[7] = 8'h67;
    mem[9'h104] = 8'h11; mem[9'h105] = 8'h22; mem[9'h106] = 8'h33; mem[9'h107] = 8'h44;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // read 0x104: request sampled at E0, ack 256 edges later (cycle E0+257)
    start_req(32'h0000_0104, 1'b0);
    wait_ack("rd104", 400, 1'b0, 32'h0, lat);
    check("rd104_lat", 32'(lat), 32'(LAT_EDGES));
    check("rd104_dat", dat_o, 32'h4433_2211);
    check("rd104_mosi", fl_cmd, 32'h0300_0104);
    @(posedge clk); #1;
    check("rd104_ack_width", {31'b0, ack}, 32'h0);

    // reset while idle clears held read data
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle_rst");
    @(negedge clk) rst = 1'b0;

    // upper address bits and [1:0] ignored
    start_req(32'hAB00_0106, 1'b0);
    wait_ack("rdAB", 400, 1'b0, 32'h0, lat);
    check("rdAB_mosi", fl_cmd, 32'h0300_0104);
    check("rdAB_dat", dat_o, 32'h4433_2211);

    // write -> one-cycle error, no SPI activity
    repeat (4) @(posedge clk);
    sck_rises = 0;
    ack_cnt = 0;
    start_req(32'h0, 1'b1);
    check("wr_err", {31'b0, err}, 32'h1);
    check("wr_ack", {31'b0, ack}, 32'h0);
    check("wr_csn", {31'b0, cs_n}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("wr_err_width", {31'b0, err}, 32'h0);
    repeat (10) @(posedge clk);
    #1 check("wr_sck_rises", 32'(sck_rises), 32'h0);
    check("wr_no_ack", 32'(ack_cnt), 32'h0);

    // abort during DATA bit 10 (edges E0+168..E0+171)
    prev = dat_o;
    ack_cnt = 0;
    start_req(32'h0, 1'b0);
    repeat (169) @(posedge clk);
    #1 check("abort_in_data", {29'b0, dbg_state}, 32'h2);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("abort_csn", {31'b0, cs_n}, 32'h1);
    check("abort_sck", {31'b0, sck}, 32'h0);
    repeat (300) @(posedge clk);
    #1 check("abort_no_ack", 32'(ack_cnt), 32'h0);
    check("abort_dat_kept", dat_o, prev);

    // reset during CMD bit 5 (edges E0+20..E0+23), then a clean read
    start_req(32'h4, 1'b0);
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("cmd_rst");
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    start_req(32'h4, 1'b0);
    wait_ack("rd4", 400, 1'b0, 32'h0, lat);
    check("rd4_lat", 32'(lat), 32'(LAT_EDGES));
    check("rd4_dat", dat_o, 32'h6745_2301);
    check("rd4_mosi", fl_cmd, 32'h0300_0004);

    // back-to-back reads with stb held
    repeat (4) @(posedge clk);
    start_req(32'h0, 1'b0);
    wait_ack("b2b0", 400, 1'b1, 32'h4, lat);
    check("b2b0_dat", dat_o, 32'hEFBE_ADDE);
    check("b2b0_mosi", fl_cmd, 32'h0300_0000);
    wait_ack("b2b1", 400, 1'b0, 32'h0, lat);
    check("b2b1_dat", dat_o, 32'h6745_2301);
    check("b2b1_mosi", fl_cmd, 32'h0300_0004);
    check("b2b_cs_high_min", {31'b0, (last_hi >= CS_HIGH_CYCLES)}, 32'h1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
